// File: rtl/matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module   : matrix_key_scanner
// Brief    : 5x4 key matrix scanner with frame-based press/release debounce.
// Revision : 1.0  initial release
// ============================================================================
module matrix_key_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clrn,
    output logic [4:0] key_drive,
    input  logic [3:0] key_sense,
    output logic [4:0] key_code,
    output logic       ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    localparam logic [7:0] c_dwell_last = 8'(SCAN_DIV - 1);
    localparam logic [3:0] c_debounce   = 4'(DEBOUNCE);

    state_t     r_state;
    logic [7:0] r_dwell;
    logic [2:0] r_line;
    logic       r_frame_hit;
    logic [4:0] r_frame_code;
    logic [4:0] r_pend_code;
    logic [3:0] r_stab_cnt;
    logic [3:0] r_rel_cnt;

    logic       w_sample;
    logic       w_frame_end;
    logic       w_line_hit;
    logic [1:0] w_sense_idx;
    logic [4:0] w_line_code;
    logic       w_hit;
    logic [4:0] w_code;
    logic [2:0] w_next_line;
    logic [3:0] w_stab_inc;
    logic [3:0] w_rel_inc;

    assign w_sample    = (r_dwell == c_dwell_last);
    assign w_frame_end = w_sample && (r_line == 3'd4);
    assign w_line_hit  = (key_sense != 4'hF);
    assign w_line_code = {r_line, w_sense_idx};
    assign w_next_line = (r_line == 3'd4) ? 3'd0 : r_line + 3'd1;
    assign w_stab_inc  = (r_stab_cnt == 4'hF) ? r_stab_cnt : r_stab_cnt + 4'd1;
    assign w_rel_inc   = (r_rel_cnt == 4'hF) ? r_rel_cnt : r_rel_cnt + 4'd1;

    // Frame result includes line 4, which is sampled in the evaluating cycle.
    assign w_hit  = r_frame_hit | w_line_hit;
    assign w_code = r_frame_hit ? r_frame_code : w_line_code;

    always_comb begin
        w_sense_idx = 2'd3;
        if (!key_sense[0])      w_sense_idx = 2'd0;
        else if (!key_sense[1]) w_sense_idx = 2'd1;
        else if (!key_sense[2]) w_sense_idx = 2'd2;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_dwell      <= 8'd0;
            r_line       <= 3'd0;
            r_frame_hit  <= 1'b0;
            r_frame_code <= 5'd0;
            r_pend_code  <= 5'd0;
            r_stab_cnt   <= 4'd0;
            r_rel_cnt    <= 4'd0;
            key_drive    <= 5'b11110;
            key_code     <= 5'd0;
            ready        <= 1'b0;
        end else begin
            if (w_sample) begin
                r_dwell   <= 8'd0;
                r_line    <= w_next_line;
                key_drive <= ~(5'd1 << w_next_line);
            end else begin
                r_dwell <= r_dwell + 8'd1;
            end

            if (w_sample && !w_frame_end && w_line_hit && !r_frame_hit) begin
                r_frame_hit  <= 1'b1;
                r_frame_code <= w_line_code;
            end

            if (w_frame_end) begin
                r_frame_hit <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_hit) begin
                            r_pend_code <= w_code;
                            r_stab_cnt  <= 4'd1;
                            if (c_debounce == 4'd1) begin
                                r_state  <= HELD;
                                key_code <= w_code;
                                ready    <= 1'b1;
                            end else begin
                                r_state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (!w_hit) begin
                            r_state    <= IDLE;
                            r_stab_cnt <= 4'd0;
                        end else if (w_code == r_pend_code) begin
                            r_stab_cnt <= w_stab_inc;
                            if (w_stab_inc >= c_debounce) begin
                                r_state  <= HELD;
                                key_code <= r_pend_code;
                                ready    <= 1'b1;
                            end
                        end else begin
                            r_pend_code <= w_code;
                            r_stab_cnt  <= 4'd1;
                        end
                    end
                    HELD: begin
                        if (!w_hit) begin
                            r_rel_cnt <= 4'd1;
                            if (c_debounce == 4'd1) begin
                                r_state <= IDLE;
                                ready   <= 1'b0;
                            end else begin
                                r_state <= REL_DB;
                            end
                        end
                    end
                    REL_DB: begin
                        if (!w_hit) begin
                            r_rel_cnt <= w_rel_inc;
                            if (w_rel_inc >= c_debounce) begin
                                r_state <= IDLE;
                                ready   <= 1'b0;
                            end
                        end else begin
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_key_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_key_scanner
// Brief    : Directed, table-driven bench for matrix_key_scanner (SCAN_DIV=4, DEBOUNCE=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_matrix_key_scanner;

    localparam int c_frame = 20;

    logic        clk;
    logic        clrn;
    logic [4:0]  key_drive;
    logic [3:0]  key_sense;
    logic [4:0]  key_code;
    logic        ready;
    logic [19:0] keys;

    int n_checks;
    int n_fail;
    int rises;
    logic prev_ready;

    typedef struct {
        logic [19:0] keys;
        int          frames;
        logic        exp_ready;
        logic [4:0]  exp_code;
    } vec_t;

    vec_t tbl [15];

    matrix_key_scanner #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .key_drive (key_drive),
        .key_sense (key_sense),
        .key_code  (key_code),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its sense line low while its drive line is low.
    always_comb begin
        key_sense = 4'hF;
        for (int d = 0; d < 5; d++)
            for (int s = 0; s < 4; s++)
                if (!key_drive[d] && keys[d*4+s]) key_sense[s] = 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (ready && !prev_ready) rises++;
            prev_ready = ready;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_drive;
        int rises_start;

        n_checks   = 0;
        n_fail     = 0;
        rises      = 0;
        prev_ready = 1'b0;

        tbl[0]  = '{20'h1 << 7,               1, 1'b0, 5'h10};
        tbl[1]  = '{20'h0,                    1, 1'b0, 5'h10};
        tbl[2]  = '{20'h0,                    2, 1'b0, 5'h10};
        tbl[3]  = '{(20'h1 << 18) | (20'h1 << 5), 1, 1'b0, 5'h10};
        tbl[4]  = '{(20'h1 << 18) | (20'h1 << 5), 1, 1'b1, 5'd5};
        tbl[5]  = '{20'h1 << 18,              2, 1'b1, 5'd5};
        tbl[6]  = '{20'h0,                    1, 1'b1, 5'd5};
        tbl[7]  = '{20'h1 << 3,               1, 1'b1, 5'd5};
        tbl[8]  = '{20'h0,                    2, 1'b0, 5'd5};
        tbl[9]  = '{20'h1 << 19,              2, 1'b1, 5'd19};
        tbl[10] = '{20'h0,                    2, 1'b0, 5'd19};
        tbl[11] = '{20'h1 << 0,               1, 1'b0, 5'd19};
        tbl[12] = '{20'h1 << 1,               1, 1'b0, 5'd19};
        tbl[13] = '{20'h1 << 1,               1, 1'b1, 5'd1};
        tbl[14] = '{20'h0,                    2, 1'b0, 5'd1};

        // Reset state and idle drive walk
        clrn = 1'b0;
        keys = 20'h0;
        tick(3);
        check("reset_drive", 32'(key_drive), 32'h1E);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_code", 32'(key_code), 32'h0);
        clrn = 1'b1;
        for (int c = 0; c < c_frame; c++) begin
            exp_drive = ~(5'd1 << (c / 4));
            check($sformatf("walk_drive_c%0d", c), 32'(key_drive), 32'(exp_drive));
            tick(1);
        end
        tick(2 * c_frame);
        check("idle_no_ready", 32'(ready), 32'h0);

        // Key 16 held from before frame 0: ready rises right after edge 40
        keys = 20'h1 << 16;
        clrn = 1'b0;
        tick(2);
        clrn = 1'b1;
        tick(2 * c_frame - 1);
        check("press_ready_early", 32'(ready), 32'h0);
        tick(1);
        check("press_ready_rise", 32'(ready), 32'h1);
        check("press_code", 32'(key_code), 32'h10);
        keys = 20'h0;
        tick(2 * c_frame - 1);
        check("release_ready_late", 32'(ready), 32'h1);
        tick(1);
        check("release_ready_fall", 32'(ready), 32'h0);
        check("release_code_kept", 32'(key_code), 32'h10);

        // Frame-aligned table: glitch, multi-key, held/release flicker, code reload
        rises_start = rises;
        for (int i = 0; i < 15; i++) begin
            keys = tbl[i].keys;
            tick(tbl[i].frames * c_frame);
            check($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d_code", i), 32'(key_code), 32'(tbl[i].exp_code));
        end
        check("tbl_ready_rises", 32'(rises - rises_start), 32'd3);

        // Reset during PRESS_DB
        keys = 20'h1 << 9;
        tick(c_frame + 5);
        clrn = 1'b0;
        #1;
        check("rst_pdb_ready", 32'(ready), 32'h0);
        check("rst_pdb_code", 32'(key_code), 32'h0);
        check("rst_pdb_drive", 32'(key_drive), 32'h1E);
        tick(2);
        clrn = 1'b1;
        tick(2 * c_frame - 1);
        check("repress_early", 32'(ready), 32'h0);
        tick(1);
        check("repress_ready", 32'(ready), 32'h1);
        check("repress_code", 32'(key_code), 32'd9);

        // Reset during HELD
        tick(7);
        clrn = 1'b0;
        #1;
        check("rst_held_ready", 32'(ready), 32'h0);
        check("rst_held_code", 32'(key_code), 32'h0);
        tick(2);
        clrn = 1'b1;
        tick(c_frame);
        check("after_held_rst_1frame", 32'(ready), 32'h0);
        tick(c_frame);
        check("after_held_rst_ready", 32'(ready), 32'h1);
        check("after_held_rst_code", 32'(key_code), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_key_scanner.md
MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clk cycles each drive line is held active; legal range 2..255.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive identical scan frames needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port key_drive  output  5  matrix drive lines, active low, at most one low at a time.
REQ-006 SHALL have port key_sense  input  4  matrix sense lines, active low; pull-ups are on the board.
REQ-007 SHALL have port key_code  output  5  code of the accepted key, equal to drive_index*4 + sense_index (0..19).
REQ-008 SHALL have port ready  output  1  level; high while an accepted key is held.

Function
REQ-009 SHALL drive lines in the order index 0,1,2,3,4,0,...; each line is low for exactly SCAN_DIV cycles; one frame is 5*SCAN_DIV cycles.
REQ-010 SHALL sample key_sense only in the last cycle of each line's dwell period, so the matrix has SCAN_DIV-1 cycles to settle.
REQ-011 SHALL keep, per frame, a pressed flag and a candidate code.
REQ-012 SHALL take as the candidate the first low sense bit found in scan order: lowest drive index first, then lowest sense index; later keys in the same frame are ignored.
REQ-013 SHALL evaluate each frame at its end, in the sampling cycle of line 4, and then clear the frame flag for the next frame.
REQ-014 SHALL implement the FSM states IDLE, PRESS_DB, HELD and REL_DB.
REQ-015 IDLE: a frame with pressed=1 SHALL load the candidate into a pending code, set the stability count to 1 and go to PRESS_DB; if DEBOUNCE=1 it SHALL go directly to HELD.
REQ-016 PRESS_DB:
- a frame with the same code SHALL increment the count; on reaching DEBOUNCE it SHALL go to HELD.
- a frame with a different code SHALL reload the pending code and set the count to 1.
- a frame with no key SHALL return to IDLE.
REQ-017 On entry to HELD, key_code SHALL load the pending code and ready SHALL rise in the cycle after the deciding frame end.
REQ-018 HELD: a frame with no key SHALL set the release count to 1 and go to REL_DB; a frame with any key, including a different code, SHALL stay in HELD and leave key_code unchanged.
REQ-019 REL_DB:
- a frame with no key SHALL increment the release count; on reaching DEBOUNCE it SHALL go to IDLE and drop ready in the next cycle.
- a frame with any key SHALL return to HELD.
REQ-020 SHALL produce exactly one ready rising edge per accepted press; ready SHALL stay high through REL_DB.
REQ-021 key_code SHALL be stable whenever ready=1 and SHALL keep its last value after ready falls.
REQ-022 Stability and release counters SHALL saturate and never wrap; the dwell and line counters SHALL wrap from SCAN_DIV-1 to 0 and from 4 to 0.

Reset
REQ-023 clrn low SHALL immediately force: key_drive=5'b11110 (line 0 active), key_code=0, ready=0, FSM=IDLE, and all counters and flags cleared.
REQ-024 Reset asserted mid-press or mid-debounce SHALL discard all progress; after clrn rises, scanning SHALL restart at line 0, dwell count 0.

Verification (SCAN_DIV=4, DEBOUNCE=2, frame=20 cycles)
REQ-025 Reset release, no keys -> key_drive walks 11110,11101,11011,10111,01111, 4 cycles each; ready stays 0 indefinitely.
REQ-026 Hold key at drive 4, sense 0 from before frame 0 -> ready rises the cycle after the end of frame 1; key_code=5'h10.
REQ-027 Release that key -> ready falls the cycle after the end of the 2nd consecutive empty frame; key_code stays 5'h10.
REQ-028 Press keys 18 and 5 together -> key_code=5 with a single ready rise; then release key 5 while holding 18 -> ready stays 1 and key_code stays 5.
REQ-029 1-frame glitch on key 7, then empty frames -> ready never rises; FSM returns to IDLE.
REQ-030 Assert clrn during PRESS_DB and during HELD -> ready=0 and key_code=0 immediately; a re-press after reset needs 2 full frames before ready rises.
